// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-register CPU control path: opcodes, ALU SELECT
// encodings, sequencer states and instruction field offsets.
package cpu_pkg;

  // Instruction opcodes (INSTR[31:24])
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU SELECT encodings
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Instruction field LSB offsets
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_TRAP = 2'd3
  } seq_state_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: opcode -> ALU SELECT, operand steering,
// latency class and illegal flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] aluop,
  output logic       imm_sel,
  output logic       neg_sel,
  output logic       is_add,
  output logic       illegal
);

  // Opcode table; unknown opcodes decode as a harmless forward plus illegal
  always_comb begin
    aluop   = ALU_FWD;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    is_add  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LOADI: imm_sel = 1'b1;
      OP_MOV:   aluop   = ALU_FWD;
      OP_ADD: begin
        aluop  = ALU_ADD;
        is_add = 1'b1;
      end
      OP_SUB: begin
        aluop   = ALU_ADD;
        neg_sel = 1'b1;
        is_add  = 1'b1;
      end
      OP_AND:  aluop   = ALU_AND;
      OP_OR:   aluop   = ALU_OR;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Control sequencer for the 8-bit ALU: accepts an instruction, registers its
// decoded controls, waits out the ALU latency and issues one write-back strobe.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcode traps until reset).
module alu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned LOGIC_LAT = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [7:0]  IMMEDIATE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  ALUOP,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic        BUSY,
  output logic        ILLEGAL
);

  seq_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rst_done_q, rst_done_d;
  logic nop_q, nop_d;
  logic [2:0] readreg1_q, readreg1_d;
  logic [2:0] readreg2_q, readreg2_d;
  logic [7:0] immediate_q, immediate_d;
  logic imm_sel_q, imm_sel_d;
  logic neg_sel_q, neg_sel_d;
  logic [2:0] aluop_q, aluop_d;
  logic [2:0] writereg_q, writereg_d;

  logic [2:0] dec_aluop;
  logic dec_imm_sel, dec_neg_sel, dec_is_add, dec_illegal;
  logic handshake;
  logic unused_field_bits;

  // Upper bits of the register fields are architecturally ignored
  assign unused_field_bits = ^{INSTR[DST_LSB+7:DST_LSB+3], INSTR[SRC1_LSB+7:SRC1_LSB+3]};

  instr_decoder u_dec (
    .opcode  (INSTR[OPC_LSB+7:OPC_LSB]),
    .aluop   (dec_aluop),
    .imm_sel (dec_imm_sel),
    .neg_sel (dec_neg_sel),
    .is_add  (dec_is_add),
    .illegal (dec_illegal)
  );

  // READY is held low for the first cycle out of reset via rst_done_q
  assign INSTR_READY = (state_q == ST_IDLE) && rst_done_q;
  assign handshake   = INSTR_VALID && INSTR_READY;
  assign BUSY        = (state_q != ST_IDLE);
  assign WRITEENABLE = (state_q == ST_WB) && !nop_q;

`ifdef ILLEGAL_TRAP_EN
  assign ILLEGAL = (state_q == ST_TRAP);
`else
  assign ILLEGAL = 1'b0;
`endif

  assign READREG1  = readreg1_q;
  assign READREG2  = readreg2_q;
  assign IMMEDIATE = immediate_q;
  assign IMM_SEL   = imm_sel_q;
  assign NEG_SEL   = neg_sel_q;
  assign ALUOP     = aluop_q;
  assign WRITEREG  = writereg_q;

  // Next-state, latency counter and control-capture logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_done_d  = 1'b1;
    nop_d       = nop_q;
    readreg1_d  = readreg1_q;
    readreg2_d  = readreg2_q;
    immediate_d = immediate_q;
    imm_sel_d   = imm_sel_q;
    neg_sel_d   = neg_sel_q;
    aluop_d     = aluop_q;
    writereg_d  = writereg_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          readreg1_d  = INSTR[SRC1_LSB+2:SRC1_LSB];
          readreg2_d  = INSTR[SRC2_LSB+2:SRC2_LSB];
          immediate_d = INSTR[SRC2_LSB+7:SRC2_LSB];
          writereg_d  = INSTR[DST_LSB+2:DST_LSB];
          imm_sel_d   = dec_imm_sel;
          neg_sel_d   = dec_neg_sel;
          aluop_d     = dec_aluop;
          cnt_d       = dec_is_add ? CNT_W'(ADD_LAT - 1) : CNT_W'(LOGIC_LAT - 1);
          if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            state_d = ST_TRAP;
`else
            state_d = ST_WB;
            nop_d   = 1'b1;
`endif
          end else begin
            state_d = ST_EXEC;
            nop_d   = 1'b0;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
        nop_d   = 1'b0;
      end
      ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = ST_TRAP;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and control registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rst_done_q  <= 1'b0;
      nop_q       <= 1'b0;
      readreg1_q  <= '0;
      readreg2_q  <= '0;
      immediate_q <= '0;
      imm_sel_q   <= 1'b0;
      neg_sel_q   <= 1'b0;
      aluop_q     <= '0;
      writereg_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_done_q  <= rst_done_d;
      nop_q       <= nop_d;
      readreg1_q  <= readreg1_d;
      readreg2_q  <= readreg2_d;
      immediate_q <= immediate_d;
      imm_sel_q   <= imm_sel_d;
      neg_sel_q   <= neg_sel_d;
      aluop_q     <= aluop_d;
      writereg_q  <= writereg_d;
    end
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed self-checking bench for alu_control_sequencer (default latencies:
// ADD_LAT=2, LOGIC_LAT=1). Honors ILLEGAL_TRAP_EN if defined.
module tb_alu_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  readreg1, readreg2, aluop, writereg;
  logic [7:0]  immediate;
  logic        imm_sel, neg_sel, writeenable, busy, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_control_sequencer #(.ADD_LAT(2), .LOGIC_LAT(1), .CNT_W(4)) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .INSTR       (instr),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .READREG1    (readreg1),
    .READREG2    (readreg2),
    .IMMEDIATE   (immediate),
    .IMM_SEL     (imm_sel),
    .NEG_SEL     (neg_sel),
    .ALUOP       (aluop),
    .WRITEREG    (writereg),
    .WRITEENABLE (writeenable),
    .BUSY        (busy),
    .ILLEGAL     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge (the handshake edge)
  task automatic issue(input logic [31:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] all_out;
    rst_n = 1'b0;
    instr = 32'hFFFF_FFFF;
    instr_valid = 1'b0;
    step();
    step();
    all_out = {readreg1, readreg2, immediate, imm_sel, neg_sel, aluop, writereg,
               writeenable, busy, illegal, instr_ready};
    n_checks++;
    if (all_out !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", all_out, 26'h0);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b busy=%b expected ready=1 busy=0", instr_ready, busy);
    end
  endtask

  // loadi r4,0x5A : LAT=1 -> WE in cycle t+1, READY in t+2
  task automatic test_loadi();
    issue(32'h0004_005A);
    n_checks++;
    if ({aluop, imm_sel, neg_sel, immediate, writereg, busy, instr_ready, writeenable}
        !== {3'b000, 1'b1, 1'b0, 8'h5A, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL loadi_decode: aluop=%b imm=%b neg=%b immv=%h wr=%0d busy=%b rdy=%b we=%b expected 000 1 0 5a 4 1 0 0",
               aluop, imm_sel, neg_sel, immediate, writereg, busy, instr_ready, writeenable);
    end
    step();
    n_checks++;
    if (writeenable !== 1'b1) begin
      n_fail++;
      $display("FAIL loadi_we_t1: got %b expected 1", writeenable);
    end
    step();
    n_checks++;
    if (writeenable !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loadi_done_t2: we=%b rdy=%b busy=%b expected 0 1 0", writeenable, instr_ready, busy);
    end
    n_checks++;
    if (immediate !== 8'h5A || writereg !== 3'd4 || imm_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL loadi_hold_idle: imm=%h wr=%0d sel=%b expected 5a 4 1", immediate, writereg, imm_sel);
    end
  endtask

  // add r1,r2,r3 : LAT=2 -> WE in cycle t+2, READY in t+3
  task automatic test_add();
    int we_seen = 0;
    issue(32'h0201_0203);
    n_checks++;
    if ({aluop, readreg1, readreg2, writereg, imm_sel, neg_sel}
        !== {3'b001, 3'd2, 3'd3, 3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_decode: aluop=%b rr1=%0d rr2=%0d wr=%0d imm=%b neg=%b expected 001 2 3 1 0 0",
               aluop, readreg1, readreg2, writereg, imm_sel, neg_sel);
    end
    step();
    n_checks++;
    if (writeenable !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_t1: we=%b busy=%b expected 0 1", writeenable, busy);
    end
    step();
    n_checks++;
    if (writeenable !== 1'b1 || instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL add_we_t2: we=%b rdy=%b expected 1 0", writeenable, instr_ready);
    end
    step();
    n_checks++;
    if (instr_ready !== 1'b1 || writeenable !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ready_t3: rdy=%b we=%b expected 1 0", instr_ready, writeenable);
    end
  endtask

  // sub r7,r0,r6 with VALID held while busy and INSTR changed underneath
  task automatic test_sub_valid_held();
    int we_count = 0;
    instr       = 32'h0307_0006;
    instr_valid = 1'b1;
    step();
    instr = 32'h0205_0101;
    for (int c = 0; c < 3; c++) begin
      if (writeenable === 1'b1) we_count++;
      n_checks++;
      if ({aluop, neg_sel, imm_sel, readreg1, readreg2, writereg}
          !== {3'b001, 1'b1, 1'b0, 3'd0, 3'd6, 3'd7}) begin
        n_fail++;
        $display("FAIL sub_hold_c%0d: aluop=%b neg=%b imm=%b rr1=%0d rr2=%0d wr=%0d expected 001 1 0 0 6 7",
                 c, aluop, neg_sel, imm_sel, readreg1, readreg2, writereg);
      end
      step();
    end
    instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (writeenable === 1'b1) we_count++;
      step();
    end
    n_checks++;
    if (we_count != 1) begin
      n_fail++;
      $display("FAIL sub_we_count: got %0d expected 1", we_count);
    end
    n_checks++;
    if (instr_ready !== 1'b1 || writereg !== 3'd7) begin
      n_fail++;
      $display("FAIL sub_idle: rdy=%b wr=%0d expected 1 7", instr_ready, writereg);
    end
  endtask

  // Two loadi back to back: second accepted the first cycle READY returns
  task automatic test_back_to_back();
    issue(32'h0002_0011);
    step();
    n_checks++;
    if (writeenable !== 1'b1 || writereg !== 3'd2) begin
      n_fail++;
      $display("FAIL b2b_first_we: we=%b wr=%0d expected 1 2", writeenable, writereg);
    end
    step();
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b expected 1", instr_ready);
    end
    issue(32'h0103_0005);
    n_checks++;
    if (busy !== 1'b1 || writereg !== 3'd3 || imm_sel !== 1'b0 || readreg1 !== 3'd0 || readreg2 !== 3'd5) begin
      n_fail++;
      $display("FAIL b2b_second: busy=%b wr=%0d imm=%b rr1=%0d rr2=%0d expected 1 3 0 0 5",
               busy, writereg, imm_sel, readreg1, readreg2);
    end
    step();
    n_checks++;
    if (writeenable !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_we: got %b expected 1", writeenable);
    end
    step();
  endtask

  task automatic test_illegal();
    int we_count = 0;
    issue(32'hFF01_0203);
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 4; c++) begin
      if (writeenable === 1'b1) we_count++;
      n_checks++;
      if (illegal !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_trap_c%0d: ill=%b rdy=%b busy=%b expected 1 0 1", c, illegal, instr_ready, busy);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (illegal !== 1'b0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_trap_clear: ill=%b rdy=%b expected 0 1", illegal, instr_ready);
    end
`else
    if (writeenable === 1'b1) we_count++;
    n_checks++;
    if (busy !== 1'b1 || instr_ready !== 1'b0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nop_t0: busy=%b rdy=%b ill=%b expected 1 0 0", busy, instr_ready, illegal);
    end
    step();
    if (writeenable === 1'b1) we_count++;
    n_checks++;
    if (instr_ready !== 1'b1 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nop_ready: rdy=%b ill=%b expected 1 0", instr_ready, illegal);
    end
`endif
    n_checks++;
    if (we_count != 0) begin
      n_fail++;
      $display("FAIL illegal_we_count: got %0d expected 0", we_count);
    end
  endtask

  // add accepted, reset asserted in EXEC: no strobe, outputs cleared
  task automatic test_reset_mid();
    logic [25:0] all_out;
    int we_count = 0;
    issue(32'h0206_0405);
    n_checks++;
    if (busy !== 1'b1 || writereg !== 3'd6) begin
      n_fail++;
      $display("FAIL midrst_accept: busy=%b wr=%0d expected 1 6", busy, writereg);
    end
    rst_n = 1'b0;
    step();
    all_out = {readreg1, readreg2, immediate, imm_sel, neg_sel, aluop, writereg,
               writeenable, busy, illegal, instr_ready};
    n_checks++;
    if (all_out !== 26'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h expected %h", all_out, 26'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (writeenable === 1'b1) we_count++;
    end
    n_checks++;
    if (we_count != 0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after: we_count=%0d rdy=%b expected 0 1", we_count, instr_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    #1;
    test_reset();
    test_loadi();
    test_add();
    test_sub_valid_held();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1);
  end

endmodule
